// File: rtl/debug_serial_tx.sv
// Snapshots seven debug bytes and sends them as one 8N1 UART frame: SYNC, 7 data bytes, XOR checksum.
// Latency: tx_o falls one cycle after a request is sampled; frame is 90 bit-times plus FRAME_GAP idle bit-times.
// No backpressure: triggers arriving while busy collapse into one pending frame; enable_i streams frames back to back.
module debug_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned FRAME_GAP    = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  debug_port1_i,
  input  logic [7:0]  debug_port2_i,
  input  logic [7:0]  debug_port3_i,
  input  logic [7:0]  debug_port4_i,
  input  logic [7:0]  debug_port5_i,
  input  logic [7:0]  debug_port6_i,
  input  logic [7:0]  debug_port7_i,
  input  logic        enable_i,
  input  logic        trigger_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic [15:0] frame_count_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((FRAME_GAP > 0) ? (FRAME_GAP - 1) : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [3:0]      r_byte_idx;
  logic            r_pending;
  logic [7:0]      r_snap [7];
  logic [7:0]      r_csum;
  logic            r_tx;
  logic            w_tx_nxt;
  logic [15:0]     r_frame_cnt;
  logic [7:0]      w_ports [7];
  logic [7:0]      w_cur_byte;
  logic            w_cnt_done;
  logic            w_gap_done;
  logic            w_req;

  assign w_ports[0] = debug_port1_i;
  assign w_ports[1] = debug_port2_i;
  assign w_ports[2] = debug_port3_i;
  assign w_ports[3] = debug_port4_i;
  assign w_ports[4] = debug_port5_i;
  assign w_ports[5] = debug_port6_i;
  assign w_ports[6] = debug_port7_i;

  assign w_cnt_done    = (r_cnt == '0);
  assign w_gap_done    = (r_gap_cnt == '0);
  assign w_req         = trigger_i | enable_i | r_pending;
  assign tx_o          = r_tx;
  assign frame_count_o = r_frame_cnt;

  // Byte currently on the wire: sync, snapshot bytes, then checksum
  always_comb begin
    w_cur_byte = SYNC_BYTE;
    case (r_byte_idx)
      4'd1:    w_cur_byte = r_snap[0];
      4'd2:    w_cur_byte = r_snap[1];
      4'd3:    w_cur_byte = r_snap[2];
      4'd4:    w_cur_byte = r_snap[3];
      4'd5:    w_cur_byte = r_snap[4];
      4'd6:    w_cur_byte = r_snap[5];
      4'd7:    w_cur_byte = r_snap[6];
      4'd8:    w_cur_byte = r_csum;
      default: w_cur_byte = SYNC_BYTE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: each non-idle state lasts whole bit-times
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_START;
      S_START: if (w_cnt_done) w_state_nxt = S_DATA;
      S_DATA:  if (w_cnt_done && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_cnt_done) begin
          if (r_byte_idx != 4'd8)  w_state_nxt = S_START;
          else if (FRAME_GAP == 0) w_state_nxt = S_IDLE;
          else                     w_state_nxt = S_GAP;
        end
      end
      S_GAP:   if (w_cnt_done && w_gap_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: busy while not idle; next line level follows the state being entered
  always_comb begin
    busy_o    = (r_state != S_IDLE);
    w_bit_nxt = 3'd0;
    if (r_state == S_DATA) w_bit_nxt = w_cnt_done ? (r_bit_idx + 3'd1) : r_bit_idx;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Datapath: snapshot, counters, pending request and the registered line driver
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx        <= 1'b1;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 4'd0;
      r_pending   <= 1'b0;
      r_csum      <= 8'd0;
      r_frame_cnt <= 16'd0;
      for (int i = 0; i < 7; i++) r_snap[i] <= 8'd0;
    end else begin
      r_tx      <= w_tx_nxt;
      r_bit_idx <= w_bit_nxt;
      if (r_state == S_IDLE) begin
        if (w_req) begin
          for (int i = 0; i < 7; i++) r_snap[i] <= w_ports[i];
          r_csum     <= w_ports[0] ^ w_ports[1] ^ w_ports[2] ^ w_ports[3] ^
                        w_ports[4] ^ w_ports[5] ^ w_ports[6];
          r_pending  <= 1'b0;
          r_byte_idx <= 4'd0;
          r_cnt      <= CNT_LOAD;
        end
      end else begin
        if (trigger_i) r_pending <= 1'b1;
        r_cnt <= w_cnt_done ? CNT_LOAD : (r_cnt - CW'(1));
        if ((r_state == S_STOP) && w_cnt_done) begin
          if (r_byte_idx != 4'd8) begin
            r_byte_idx <= r_byte_idx + 4'd1;
          end else begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_gap_cnt   <= GAP_LOAD;
          end
        end
        if ((r_state == S_GAP) && w_cnt_done) r_gap_cnt <= r_gap_cnt - GW'(1);
      end
    end
  end

endmodule
